// File: rtl/compl_pkg.sv
// Shared types and constants for the complement sequencer.
package compl_pkg;

  typedef enum logic [1:0] {
    PASS        = 2'b00,
    ONES        = 2'b01,
    TWOS        = 2'b10,
    TWOS_SERIAL = 2'b11
  } mode_t;

  typedef enum logic {
    IDLE   = 1'b0,
    SERIAL = 1'b1
  } state_t;

  localparam int MAX_WIDTH = 32;

  // Operand whose two's complement wraps back onto itself: MSB set, rest zero.
  function automatic logic [MAX_WIDTH-1:0] min_neg(input int width);
    return MAX_WIDTH'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/compl_core.sv
// Combinational parallel complement path: (Inp, mode) -> (Out, ovf).
module compl_core
  import compl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] Inp,
  input  mode_t            mode,
  output logic [WIDTH-1:0] Out,
  output logic             ovf
);

  localparam logic [MAX_WIDTH-1:0] MIN_NEG_FULL = min_neg(WIDTH);
  localparam logic [WIDTH-1:0]     MIN_NEG      = MIN_NEG_FULL[WIDTH-1:0];

  logic [WIDTH-1:0] w_twos;

  assign w_twos = ~Inp + WIDTH'(1);

  // The serial encoding maps to the same arithmetic result as the parallel one.
  always_comb begin
    Out = Inp;
    ovf = 1'b0;
    case (mode)
      PASS:              Out = Inp;
      ONES:              Out = ~Inp;
      TWOS, TWOS_SERIAL: begin
        Out = w_twos;
        ovf = (Inp == MIN_NEG);
      end
      default:           Out = Inp;
    endcase
  end

endmodule

// File: rtl/compl_seq.sv
// Handshaked complement unit with registered output and bit-serial two's complement.
//   state  | meaning
//   IDLE   | waiting for an operand; parallel modes load the output register directly
//   SERIAL | one operand bit per cycle, LSB first, until the counter reaches WIDTH-1
module compl_seq
  import compl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Inp,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic             ovf,
  output logic             busy
);

  localparam int                   CW           = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]        CNT_LAST     = CW'(WIDTH - 1);
  localparam logic [MAX_WIDTH-1:0] MIN_NEG_FULL = min_neg(WIDTH);
  localparam logic [WIDTH-1:0]     MIN_NEG      = MIN_NEG_FULL[WIDTH-1:0];

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_op;
  logic [WIDTH-1:0] r_acc;
  logic             r_seen_one;
  logic [WIDTH-1:0] r_out;
  logic             r_ovf;
  logic             r_out_valid;

  mode_t            w_mode;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_load_par;
  logic [WIDTH-1:0] w_core_out;
  logic             w_core_ovf;
  logic             w_bit_in;
  logic             w_bit_out;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_serial_done;
  logic             w_serial_ovf;

  assign w_mode     = mode_t'(mode);
  assign w_in_ready = (r_state == IDLE) & (~r_out_valid | out_ready) & ~reset;
  assign w_accept   = in_valid & w_in_ready;
  assign w_load_par = w_accept & (w_mode != TWOS_SERIAL);

  compl_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .Inp  (Inp),
    .mode (w_mode),
    .Out  (w_core_out),
    .ovf  (w_core_ovf)
  );

  // Serial two's complement: copy bits up to and including the first one, invert the rest.
  assign w_bit_in      = r_op[r_cnt];
  assign w_bit_out     = r_seen_one ? ~w_bit_in : w_bit_in;
  assign w_serial_done = (r_state == SERIAL) & (r_cnt == CNT_LAST);
  assign w_serial_ovf  = (r_op == MIN_NEG);

  always_comb begin
    w_acc_next        = r_acc;
    w_acc_next[r_cnt] = w_bit_out;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_op        <= '0;
      r_acc       <= '0;
      r_seen_one  <= 1'b0;
      r_out       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept && (w_mode == TWOS_SERIAL)) begin
            r_op       <= Inp;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_seen_one <= 1'b0;
            r_state    <= SERIAL;
          end
        end
        SERIAL: begin
          r_acc      <= w_acc_next;
          r_seen_one <= r_seen_one | w_bit_in;
          r_cnt      <= r_cnt + CW'(1);
          if (w_serial_done) begin
            r_cnt   <= '0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      // Serial accepts need a free or draining output register, so the two loads never collide.
      if (w_load_par) begin
        r_out       <= w_core_out;
        r_ovf       <= w_core_ovf;
        r_out_valid <= 1'b1;
      end else if (w_serial_done) begin
        r_out       <= w_acc_next;
        r_ovf       <= w_serial_ovf;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign Out       = r_out;
  assign ovf       = r_ovf;
  assign busy      = (r_state == SERIAL);

endmodule

// File: doc/compl_seq.md
# compl_seq

Parametrised, handshaked complement unit. Each accepted WIDTH-bit operand is passed through, one's-complemented or two's-complemented. Two's complement can run in a parallel 1-cycle form or a bit-serial LSB-first form that takes WIDTH cycles. The block sits between a valid/ready producer and consumer in the datapath, and replaces ad-hoc combinational complementers wherever registered results, back-pressure or overflow reporting are needed.

## Interface
Parameters:
- WIDTH, 4: operand width in bits; legal range 2..32.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand offered.
- in_ready  out  1  operand can be accepted this cycle.
- Inp  in  WIDTH  operand.
- mode  in  2  00 PASS, 01 ONES, 10 TWOS, 11 TWOS_SERIAL; sampled only on accept.
- out_valid  out  1  result held in the output register.
- out_ready  in  1  consumer takes the result.
- Out  out  WIDTH  result.
- ovf  out  1  the two's complement of the held result overflowed; qualified by out_valid.
- busy  out  1  serial operation in progress.

## Operation
- Accept: in_valid & in_ready at a rising edge. Inp and mode are captured at that edge.
- in_ready = (state == IDLE) & (~out_valid | out_ready) & ~reset. This is combinational from registered state and out_ready.
- Results per mode:
  - PASS: Out = Inp, ovf = 0.
  - ONES: Out = ~Inp, ovf = 0.
  - TWOS: Out = ~Inp + 1, truncated to WIDTH bits. ovf = 1 only when Inp = 1 followed by WIDTH-1 zeros; Out then equals Inp.
  - TWOS_SERIAL: bit-exact identical to TWOS, including ovf.
- State machine:
  - IDLE: an accept in modes 00/01/10 loads the output register directly. An accept in mode 11 loads the shift register, clears the bit counter, clears the seen_one flag, and moves to SERIAL.
  - SERIAL: one bit per cycle, LSB first. Output bit = seen_one ? ~b : b. Then seen_one |= b. The counter increments each cycle.
    - When counter = WIDTH-1, load the output register with the assembled result and ovf, then return to IDLE.
    - ovf is computed from the captured operand (MSB set, all other bits zero).
- Output register:
  - Holds Out and ovf while out_valid & ~out_ready.
  - Cleared to invalid on out_valid & out_ready when no new load happens in the same cycle.
  - Load and drain in the same cycle is allowed: the register takes the new value and out_valid stays 1.
- busy = (state == SERIAL).
- A serial accept requires the output register to be free or draining at the accept edge. It is therefore always free when the serial operation completes; no stall logic is needed in SERIAL.
- Changes on mode or Inp while not accepting have no effect.

## Timing
- Reset values: out_valid 0, Out 0, ovf 0, busy 0, state IDLE, counter 0. in_ready is 0 while reset is high and 1 in the first cycle after it falls.
- Parallel modes:
  - Accept at edge T gives out_valid = 1 from edge T to T+1 onward.
  - Throughput is 1 per cycle when out_ready is held high.
- Serial mode:
  - Accept at edge T; busy is high after edge T.
  - Result loads at edge T+WIDTH; out_valid is high after edge T+WIDTH.
  - in_ready is 0 from T until state returns to IDLE, so the next accept is possible at edge T+WIDTH+1 at the earliest.
- Back-pressure: Out and ovf stay stable while out_valid & ~out_ready.
- Reset asserted mid-SERIAL or with out_valid = 1: the next edge discards the operation and forces all reset values. No partial result is ever emitted.

## Structure
- Package compl_pkg:
  - mode_t: 2-bit enum PASS/ONES/TWOS/TWOS_SERIAL.
  - state_t: IDLE/SERIAL.
  - Function min_neg(WIDTH), the overflow operand pattern.
- Sub-module compl_core: combinational parallel path, (Inp, mode) -> (Out, ovf). It is reused by the parallel load and is a separate unit-test target.
- Counter width: $clog2(WIDTH).

## Test plan
- Reset: hold reset 3 cycles, with in_valid = 1 during reset -> out_valid 0, Out 0, in_ready 0. After release, in_ready = 1 and nothing was accepted.
- WIDTH = 4, out_ready = 1, one accept per cycle:
  - Inp 0101 with mode 00 -> 0101.
  - Inp 0101 with mode 01 -> 1010.
  - Inp 0101 with mode 10 -> 1011.
  - Inp 0000 with mode 10 -> 0000, ovf 0.
  - Each result appears one cycle after its accept.
- WIDTH = 4, mode 10, Inp 1000 -> Out 1000, ovf 1. Mode 11, Inp 1000 -> same, arriving 4 cycles after the accept.
- WIDTH = 8, mode 11, Inp 00110100 -> busy high 8 cycles, in_ready low, then Out 11001100, ovf 0. Exhaustive sweep of all 256 operands in mode 11 matches the mode 10 results.
- Back-pressure: out_ready = 0 for 5 cycles after a result -> Out stable, in_ready 0. Raise out_ready together with in_valid -> drain and accept in the same cycle, with out_valid continuously 1.
- WIDTH = 4, reset asserted 2 cycles into a serial operation -> next cycle busy 0, out_valid 0, and no result is produced.
